// File: rtl/fxu_rs.sv
// Reservation station for the fixed-point unit: holds dispatched ops until both operands
// are valid, snoops the FXU result broadcast, and issues the lowest ready slot each cycle.
module fxu_rs #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [3:0]  disp_opcode,
  input  logic [3:0]  disp_rob_index,
  input  logic        disp_a_rdy,
  input  logic        disp_b_rdy,
  input  logic [15:0] disp_va,
  input  logic [15:0] disp_vb,
  input  logic [3:0]  disp_a_tag,
  input  logic [3:0]  disp_b_tag,
  input  logic [7:0]  disp_i,
  input  logic        cdb_valid,
  input  logic [3:0]  cdb_rob_index,
  input  logic [15:0] cdb_value,
  output logic        issue_valid,
  output logic [3:0]  issue_opcode,
  output logic [3:0]  issue_index,
  output logic [15:0] issue_va,
  output logic [15:0] issue_vb,
  output logic [7:0]  issue_i,
  output logic [3:0]  occupancy
);

  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_a_rdy;
  logic [DEPTH-1:0] ent_b_rdy;
  logic [3:0]       ent_opcode [DEPTH];
  logic [3:0]       ent_rob    [DEPTH];
  logic [3:0]       ent_a_tag  [DEPTH];
  logic [3:0]       ent_b_tag  [DEPTH];
  logic [15:0]      ent_va     [DEPTH];
  logic [15:0]      ent_vb     [DEPTH];
  logic [7:0]       ent_i      [DEPTH];

  logic [SW-1:0] free_slot;
  logic [SW-1:0] cand_slot;
  logic          cand_found;
  logic          accept;
  logic          issue_fire;
  logic          a_cap;
  logic          b_cap;

  assign disp_ready = (occupancy < 4'(DEPTH));
  assign accept     = disp_valid & disp_ready & ~flush;
  assign issue_fire = cand_found & ~flush;

  // A dispatched operand whose producer is broadcasting right now is stored as ready.
  assign a_cap = ~disp_a_rdy & cdb_valid & (disp_a_tag == cdb_rob_index);
  assign b_cap = ~disp_b_rdy & cdb_valid & (disp_b_tag == cdb_rob_index);

  // Descending scans so the lowest-numbered match is the one that sticks.
  always_comb begin
    free_slot  = '0;
    cand_slot  = '0;
    cand_found = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!ent_valid[k]) begin
        free_slot = SW'(k);
      end
      if (ent_valid[k] && ent_a_rdy[k] && ent_b_rdy[k]) begin
        cand_slot  = SW'(k);
        cand_found = 1'b1;
      end
    end
  end

  always_comb begin
    issue_valid  = 1'b0;
    issue_opcode = '0;
    issue_index  = '0;
    issue_va     = '0;
    issue_vb     = '0;
    issue_i      = '0;
    if (issue_fire) begin
      issue_valid  = 1'b1;
      issue_opcode = ent_opcode[cand_slot];
      issue_index  = ent_rob[cand_slot];
      issue_va     = ent_va[cand_slot];
      issue_vb     = ent_vb[cand_slot];
      issue_i      = ent_i[cand_slot];
    end
  end

  // Snoop first, then retire the issued slot, then fill the free slot; they never overlap.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ent_valid <= '0;
      occupancy <= '0;
    end else begin
      if (cdb_valid) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (ent_valid[k] && !ent_a_rdy[k] && (ent_a_tag[k] == cdb_rob_index)) begin
            ent_a_rdy[k] <= 1'b1;
            ent_va[k]    <= cdb_value;
          end
          if (ent_valid[k] && !ent_b_rdy[k] && (ent_b_tag[k] == cdb_rob_index)) begin
            ent_b_rdy[k] <= 1'b1;
            ent_vb[k]    <= cdb_value;
          end
        end
      end
      if (issue_fire) begin
        ent_valid[cand_slot] <= 1'b0;
      end
      if (accept) begin
        ent_valid[free_slot]  <= 1'b1;
        ent_opcode[free_slot] <= disp_opcode;
        ent_rob[free_slot]    <= disp_rob_index;
        ent_a_rdy[free_slot]  <= disp_a_rdy | a_cap;
        ent_b_rdy[free_slot]  <= disp_b_rdy | b_cap;
        ent_va[free_slot]     <= a_cap ? cdb_value : disp_va;
        ent_vb[free_slot]     <= b_cap ? cdb_value : disp_vb;
        ent_a_tag[free_slot]  <= disp_a_tag;
        ent_b_tag[free_slot]  <= disp_b_tag;
        ent_i[free_slot]      <= disp_i;
      end
      occupancy <= occupancy + {3'b000, accept} - {3'b000, issue_fire};
    end
  end

endmodule

// File: tb/tb_fxu_rs.sv
// Directed testbench for fxu_rs: inputs change on the falling edge, outputs are
// checked 1ns later, well away from the rising edge.
module tb_fxu_rs;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_opcode;
  logic [3:0]  disp_rob_index;
  logic        disp_a_rdy;
  logic        disp_b_rdy;
  logic [15:0] disp_va;
  logic [15:0] disp_vb;
  logic [3:0]  disp_a_tag;
  logic [3:0]  disp_b_tag;
  logic [7:0]  disp_i;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_index;
  logic [15:0] cdb_value;
  logic        issue_valid;
  logic [3:0]  issue_opcode;
  logic [3:0]  issue_index;
  logic [15:0] issue_va;
  logic [15:0] issue_vb;
  logic [7:0]  issue_i;
  logic [3:0]  occupancy;

  int errors = 0;
  int checks = 0;

  fxu_rs #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_rob_index(disp_rob_index),
    .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy),
    .disp_va(disp_va), .disp_vb(disp_vb),
    .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag), .disp_i(disp_i),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_index(issue_index),
    .issue_va(issue_va), .issue_vb(issue_vb), .issue_i(issue_i),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    disp_valid     = 1'b0;
    disp_opcode    = '0;
    disp_rob_index = '0;
    disp_a_rdy     = 1'b0;
    disp_b_rdy     = 1'b0;
    disp_va        = '0;
    disp_vb        = '0;
    disp_a_tag     = '0;
    disp_b_tag     = '0;
    disp_i         = '0;
    cdb_valid      = 1'b0;
    cdb_rob_index  = '0;
    cdb_value      = '0;
    flush          = 1'b0;
    reset          = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] rob,
                               input logic ar, input logic [15:0] va, input logic [3:0] at,
                               input logic br, input logic [15:0] vb, input logic [3:0] bt,
                               input logic [7:0] imm);
    disp_valid     = 1'b1;
    disp_opcode    = op;
    disp_rob_index = rob;
    disp_a_rdy     = ar;
    disp_va        = va;
    disp_a_tag     = at;
    disp_b_rdy     = br;
    disp_vb        = vb;
    disp_b_tag     = bt;
    disp_i         = imm;
  endtask

  task automatic broadcast(input logic [3:0] rob, input logic [15:0] val);
    cdb_valid     = 1'b1;
    cdb_rob_index = rob;
    cdb_value     = val;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    idle();
    #1;
    checkOutput("rst_occ", 16'(occupancy), 16'd0);
    checkOutput("rst_ready", 16'(disp_ready), 16'd1);
    checkOutput("rst_ivalid", 16'(issue_valid), 16'd0);
    checkOutput("rst_iop", 16'(issue_opcode), 16'd0);
    checkOutput("rst_iva", issue_va, 16'd0);

    // Both operands ready: one cycle of residency, then issue.
    applyStimulus(4'd0, 4'd3, 1'b1, 16'h0005, 4'd0, 1'b1, 16'h0007, 4'd0, 8'h11);
    #1;
    checkOutput("t1_no_early_issue", 16'(issue_valid), 16'd0);
    tick(); idle(); #1;
    checkOutput("t1_ivalid", 16'(issue_valid), 16'd1);
    checkOutput("t1_op", 16'(issue_opcode), 16'd0);
    checkOutput("t1_idx", 16'(issue_index), 16'd3);
    checkOutput("t1_va", issue_va, 16'h0005);
    checkOutput("t1_vb", issue_vb, 16'h0007);
    checkOutput("t1_i", 16'(issue_i), 16'h0011);
    checkOutput("t1_occ1", 16'(occupancy), 16'd1);
    tick(); #1;
    checkOutput("t1_occ0", 16'(occupancy), 16'd0);
    checkOutput("t1_idle", 16'(issue_valid), 16'd0);

    // Operand A waits on tag 1 until the broadcast.
    applyStimulus(4'd1, 4'd2, 1'b0, 16'h0000, 4'd1, 1'b1, 16'h0002, 4'd0, 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick(); idle(); #1;
      checkOutput("t2_wait", 16'(issue_valid), 16'd0);
    end
    broadcast(4'd1, 16'h0010);
    #1;
    checkOutput("t2_bcast_cycle", 16'(issue_valid), 16'd0);
    tick(); idle(); #1;
    checkOutput("t2_ivalid", 16'(issue_valid), 16'd1);
    checkOutput("t2_op", 16'(issue_opcode), 16'd1);
    checkOutput("t2_idx", 16'(issue_index), 16'd2);
    checkOutput("t2_va", issue_va, 16'h0010);
    checkOutput("t2_vb", issue_vb, 16'h0002);
    tick(); #1;
    checkOutput("t2_occ0", 16'(occupancy), 16'd0);

    // Dispatch and broadcast of the missing tag in the same cycle.
    applyStimulus(4'd2, 4'd7, 1'b0, 16'h0000, 4'd5, 1'b1, 16'h0000, 4'd0, 8'h00);
    broadcast(4'd5, 16'h1234);
    tick(); idle(); #1;
    checkOutput("t3_ivalid", 16'(issue_valid), 16'd1);
    checkOutput("t3_idx", 16'(issue_index), 16'd7);
    checkOutput("t3_va", issue_va, 16'h1234);
    tick(); #1;
    checkOutput("t3_occ0", 16'(occupancy), 16'd0);

    // Fill all four slots with blocked entries, then release slots 1 and 2 with tag 12.
    applyStimulus(4'd0, 4'd8,  1'b0, 16'h0000, 4'd9,  1'b1, 16'h0001, 4'd0,  8'h00);
    tick();
    applyStimulus(4'd1, 4'd10, 1'b0, 16'h0000, 4'd12, 1'b1, 16'h0002, 4'd0,  8'h00);
    tick();
    applyStimulus(4'd0, 4'd11, 1'b1, 16'h0003, 4'd0,  1'b0, 16'h0000, 4'd12, 8'h00);
    tick();
    applyStimulus(4'd0, 4'd13, 1'b0, 16'h0000, 4'd14, 1'b1, 16'h0004, 4'd0,  8'h00);
    #1;
    checkOutput("t4_ready_at3", 16'(disp_ready), 16'd1);
    checkOutput("t4_occ3", 16'(occupancy), 16'd3);
    tick();
    applyStimulus(4'd4, 4'd15, 1'b1, 16'h0F0F, 4'd0, 1'b1, 16'h0000, 4'd0, 8'h5A);
    #1;
    checkOutput("t4_occ4", 16'(occupancy), 16'd4);
    checkOutput("t4_full_ready", 16'(disp_ready), 16'd0);
    checkOutput("t4_blocked", 16'(issue_valid), 16'd0);
    tick();
    broadcast(4'd12, 16'h00AA);
    #1;
    checkOutput("t4_held_occ", 16'(occupancy), 16'd4);
    checkOutput("t4_held_noissue", 16'(issue_valid), 16'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    checkOutput("t4_s1_valid", 16'(issue_valid), 16'd1);
    checkOutput("t4_s1_idx", 16'(issue_index), 16'd10);
    checkOutput("t4_s1_va", issue_va, 16'h00AA);
    checkOutput("t4_s1_vb", issue_vb, 16'h0002);
    checkOutput("t4_s1_ready", 16'(disp_ready), 16'd0);
    tick(); #1;
    checkOutput("t4_s2_valid", 16'(issue_valid), 16'd1);
    checkOutput("t4_s2_idx", 16'(issue_index), 16'd11);
    checkOutput("t4_s2_va", issue_va, 16'h0003);
    checkOutput("t4_s2_vb", issue_vb, 16'h00AA);
    checkOutput("t4_s2_ready", 16'(disp_ready), 16'd1);
    checkOutput("t4_s2_occ", 16'(occupancy), 16'd3);
    tick(); idle(); #1;
    checkOutput("t4_new_valid", 16'(issue_valid), 16'd1);
    checkOutput("t4_new_idx", 16'(issue_index), 16'd15);
    checkOutput("t4_new_op", 16'(issue_opcode), 16'd4);
    checkOutput("t4_new_va", issue_va, 16'h0F0F);
    checkOutput("t4_new_i", 16'(issue_i), 16'h005A);
    checkOutput("t4_swap_occ", 16'(occupancy), 16'd3);
    tick(); #1;
    checkOutput("t4_occ2", 16'(occupancy), 16'd2);
    checkOutput("t4_rest_blocked", 16'(issue_valid), 16'd0);

    // Flush with occupancy 3, one entry ready, and a dispatch in the flush cycle.
    applyStimulus(4'd0, 4'd1, 1'b1, 16'h0009, 4'd0, 1'b1, 16'h0009, 4'd0, 8'h00);
    tick();
    applyStimulus(4'd0, 4'd6, 1'b1, 16'h0001, 4'd0, 1'b1, 16'h0001, 4'd0, 8'h00);
    flush = 1'b1;
    #1;
    checkOutput("t5_occ3", 16'(occupancy), 16'd3);
    checkOutput("t5_flush_ivalid", 16'(issue_valid), 16'd0);
    checkOutput("t5_flush_ia", issue_va, 16'h0000);
    tick(); idle();
    broadcast(4'd9, 16'h0001);
    #1;
    checkOutput("t5_occ0", 16'(occupancy), 16'd0);
    checkOutput("t5_no_stored", 16'(issue_valid), 16'd0);
    checkOutput("t5_ready", 16'(disp_ready), 16'd1);
    tick();
    broadcast(4'd14, 16'h0002);
    #1;
    checkOutput("t5_bcast9_noissue", 16'(issue_valid), 16'd0);
    tick(); idle(); #1;
    checkOutput("t5_bcast14_noissue", 16'(issue_valid), 16'd0);

    // Reset mid-stream with occupancy 2 and a live broadcast.
    applyStimulus(4'd1, 4'd4, 1'b0, 16'h0000, 4'd6, 1'b1, 16'h0001, 4'd0, 8'h00);
    tick();
    applyStimulus(4'd2, 4'd5, 1'b1, 16'h0001, 4'd0, 1'b0, 16'h0000, 4'd6, 8'h00);
    tick(); idle();
    reset = 1'b1;
    broadcast(4'd6, 16'h7777);
    #1;
    checkOutput("t6_occ2", 16'(occupancy), 16'd2);
    tick(); idle(); #1;
    checkOutput("t6_occ0", 16'(occupancy), 16'd0);
    checkOutput("t6_ready", 16'(disp_ready), 16'd1);
    checkOutput("t6_ivalid", 16'(issue_valid), 16'd0);
    checkOutput("t6_idx", 16'(issue_index), 16'd0);
    checkOutput("t6_vb", issue_vb, 16'h0000);
    broadcast(4'd6, 16'h7777);
    tick(); idle(); #1;
    checkOutput("t6_no_issue", 16'(issue_valid), 16'd0);

    // A and B waiting on the same tag both capture from one broadcast.
    applyStimulus(4'd3, 4'd9, 1'b0, 16'h0000, 4'd3, 1'b0, 16'h0000, 4'd3, 8'hC3);
    tick(); idle();
    broadcast(4'd3, 16'h0042);
    tick(); idle(); #1;
    checkOutput("t7_ivalid", 16'(issue_valid), 16'd1);
    checkOutput("t7_va", issue_va, 16'h0042);
    checkOutput("t7_vb", issue_vb, 16'h0042);
    checkOutput("t7_op", 16'(issue_opcode), 16'd3);
    checkOutput("t7_i", 16'(issue_i), 16'h00C3);
    tick(); #1;
    checkOutput("t7_occ0", 16'(occupancy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fxu_rs.md
# fxu_rs

Reservation station feeding the fixed-point execution unit (FXU). Holds dispatched FXU instructions (add, sub, mov, movl, movh) until both source operands are available. Captures missing operands by snooping the FXU result broadcast (valid, ROB index, 16-bit value). Issues at most one ready instruction per cycle on the FXU issue port (opcode, ROB index, va, vb, i). Sits between the dispatch stage and the FXU; it is the producer side of the FXU's input interface.

## Interface
- DEPTH, 4, number of entries (2..8); slot indices 0..DEPTH-1
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears all entries
- flush  in  1  synchronous squash; clears all entries at the edge
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept a dispatch this cycle
- disp_opcode  in  4  FXU opcode, stored verbatim
- disp_rob_index  in  4  destination ROB index
- disp_a_rdy / disp_b_rdy  in  1 each  operand A/B value already valid
- disp_va / disp_vb  in  16 each  operand value, meaningful when the matching rdy is 1
- disp_a_tag / disp_b_tag  in  4 each  producing ROB index, meaningful when the matching rdy is 0
- disp_i  in  8  immediate
- cdb_valid  in  1  result broadcast valid (the FXU's out_valid)
- cdb_rob_index  in  4  broadcast tag
- cdb_value  in  16  broadcast value
- issue_valid  out  1  drives the FXU in_valid
- issue_opcode  out  4; issue_index  out  4; issue_va  out  16; issue_vb  out  16; issue_i  out  8
- occupancy  out  4  number of valid entries (registered)

## Operation
- Entry fields: valid, opcode, rob_index, a_rdy, va, a_tag, b_rdy, vb, b_tag, i.
- Dispatch is accepted when disp_valid & disp_ready & ~flush.
  - The entry is written into the lowest-numbered free slot.
- disp_ready = (occupancy < DEPTH), from registered state only.
  - A slot freed by an issue in the same cycle is not reusable until the next cycle.
- Operands not used by an opcode: dispatch marks them ready (rdy=1). The station does not decode opcodes.
- Snoop: each cycle cdb_valid is high, every valid entry with a non-ready operand whose tag equals cdb_rob_index captures cdb_value and sets that rdy bit.
  - A and B with the same tag both capture.
- Same-cycle dispatch/broadcast: if a dispatched non-ready operand's tag equals cdb_rob_index while cdb_valid is high, the operand is stored ready with cdb_value.
- Selection: lowest-numbered slot with valid & a_rdy & b_rdy, evaluated on registered state.
  - issue_* are combinational from the selected slot; that slot is invalidated at the edge.
- No backpressure: the FXU always accepts an issue.
- With no candidate, issue_valid=0 and all issue_* data outputs are 0.
- flush high:
  - issue_valid forced 0.
  - Any dispatch that cycle is ignored.
  - All entries are invalidated at the edge.
  - A snoop that cycle has no lasting effect.
- reset has priority over flush and produces the same cleared state.
- occupancy next = occupancy + accepted dispatch - issue, or 0 on reset/flush.

## Timing
- Reset values:
  - All entries invalid; occupancy=0; disp_ready=1.
  - issue_valid=0; issue_opcode/index/va/vb/i = 0.
- Dispatch with both operands ready at edge N: eligible to issue in cycle N+1, i.e. a 1-cycle minimum residency.
- Operand captured from a broadcast at edge N: entry eligible in cycle N+1.
- Issue-to-result: the FXU registers its inputs, so the issued tag appears on the CDB one cycle after issue_valid.
  - A dependent entry captures it at that edge and issues the cycle after.
- Full: with occupancy=DEPTH, disp_ready=0 and held dispatches wait.
  - Simultaneous issue and dispatch while below full keep occupancy unchanged.
- Throughput: at most one dispatch and one issue per cycle.

## Test plan
- Reset, then dispatch add rob=3, va=0x0005, vb=0x0007, both ready -> next cycle issue_valid=1, opcode=0, index=3, va=5, vb=7; occupancy returns to 0.
- Dispatch sub rob=2 with A tag=1 not ready and vb=0x0002; wait 3 cycles (no issue); drive cdb rob=1 value=0x0010 -> issue one cycle later with va=0x0010, vb=2.
- Dispatch with a_tag=5 not ready in the same cycle cdb_valid=1, rob=5, value=0x1234 -> stored ready; issues next cycle with va=0x1234.
- Fill DEPTH=4 ready entries while issue is blocked by tags -> disp_ready=0 at occupancy 4.
  - Broadcast a value that readies slots 1 and 2 -> slot 1 issues first, slot 2 the following cycle; disp_ready=1 after the first issue edge.
- Occupancy 3 with one entry ready; assert flush for one cycle along with a dispatch -> issue_valid=0 that cycle, occupancy=0 next cycle, and the flushed-cycle dispatch is not stored.
- Assert reset mid-stream with occupancy 2 and cdb_valid=1 -> all outputs at reset values next cycle; a subsequent matching broadcast causes no issue.
